// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder.
// State encodings, enables and the default word-address width.
package dmem_responder_pkg;

    localparam logic [31:0] ZeroWord    = 32'h0000_0000;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;

    localparam logic [1:0] DMEM_IDLE = 2'd0;
    localparam logic [1:0] DMEM_WAIT = 2'd1;
    localparam logic [1:0] DMEM_DONE = 2'd2;

    localparam int DMEM_AW = 12;

endpackage

// File: rtl/dmem_responder_bank_array.sv
// Four byte-wide banks with per-lane write enables.
// One synchronous write port, one asynchronous read port.
module dmem_bank_array #(
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic [3:0]    lane_we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0] bank_q [2**AW];

        always_ff @(posedge clk) begin
            if (lane_we_i[k]) begin
                bank_q[waddr_i] <= wdata_i[8*k +: 8];
            end
        end

        assign rdata_o[8*k +: 8] = bank_q[raddr_i];
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane RAM behind a wait-state FSM
// that stalls the pipeline until the access completes.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = DMEM_AW,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stallreq_o,
    output logic        err_o
);

    logic [ADDR_WIDTH-1:0] widx;
    logic                  oor;
    logic [31:0]           rdata;
    logic [3:0]            lane_we;

    assign widx = addr_i[ADDR_WIDTH+1:2];
    assign oor  = |addr_i[31:ADDR_WIDTH+2];

    dmem_bank_array #(
        .AW (ADDR_WIDTH)
    ) u_banks (
        .clk       (clk),
        .lane_we_i (lane_we),
        .waddr_i   (widx),
        .wdata_i   (data_i),
        .raddr_i   (widx),
        .rdata_o   (rdata)
    );

    if (WAIT_CYCLES == 0) begin : g_zero
        // Reset gates the write so an edge under reset never commits.
        assign lane_we = (rst && ce_i == ChipEnable &&
                          we_i == WriteEnable && !oor) ? sel_i : 4'b0000;
        assign data_o     = (ce_i && !we_i && !oor) ? rdata : ZeroWord;
        assign err_o      = ce_i & oor;
        assign stallreq_o = 1'b0;
    end else begin : g_fsm
        logic [1:0]  state_q, state_d;
        logic [3:0]  cnt_q, cnt_d;
        logic [31:0] data_q, data_d;
        logic        err_q, err_d;
        logic        commit;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            data_d  = ZeroWord;
            err_d   = 1'b0;
            commit  = 1'b0;
            case (state_q)
                DMEM_IDLE: begin
                    if (ce_i == ChipEnable) begin
                        state_d = DMEM_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
                DMEM_WAIT: begin
                    if (ce_i != ChipEnable) begin
                        state_d = DMEM_IDLE;
                        cnt_d   = 4'd0;
                    end else if (cnt_q == 4'(WAIT_CYCLES)) begin
                        commit  = 1'b1;
                        data_d  = (!we_i && !oor) ? rdata : ZeroWord;
                        err_d   = oor;
                        state_d = DMEM_DONE;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                DMEM_DONE: state_d = DMEM_IDLE;
                default: begin
                    state_d = DMEM_IDLE;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= DMEM_IDLE;
                cnt_q   <= 4'd0;
                data_q  <= ZeroWord;
                err_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                data_q  <= data_d;
                err_q   <= err_d;
            end
        end

        assign lane_we = (commit && rst && we_i == WriteEnable && !oor)
                         ? sel_i : 4'b0000;
        assign stallreq_o = rst && ((state_q == DMEM_IDLE && ce_i) ||
                                    state_q == DMEM_WAIT);
        assign data_o = data_q;
        assign err_o  = err_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: directed plus random requests against a
// word-array reference model, for N=2 and zero-wait instances.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        ce = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  sel = '0;
    logic [31:0] rdata;
    logic        stall, err;

    logic        z_ce = 1'b0, z_we = 1'b0;
    logic [31:0] z_addr = '0, z_wdata = '0;
    logic [3:0]  z_sel = '0;
    logic [31:0] z_rdata;
    logic        z_stall, z_err;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] mem_m [4096];
    logic [31:0] mem_z [4096];

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst), .ce_i(ce), .we_i(we), .addr_i(addr),
        .sel_i(sel), .data_i(wdata), .data_o(rdata),
        .stallreq_o(stall), .err_o(err)
    );

    dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_zw (
        .clk(clk), .rst(rst), .ce_i(z_ce), .we_i(z_we), .addr_i(z_addr),
        .sel_i(z_sel), .data_i(z_wdata), .data_o(z_rdata),
        .stallreq_o(z_stall), .err_o(z_err)
    );

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int k = 0; k < 4; k++)
            if (s[k]) r[8*k +: 8] = d[8*k +: 8];
        return r;
    endfunction

    function automatic logic out_of_range(input logic [31:0] a);
        return a >= 32'h0000_4000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on the N=2 instance and check it against the model.
    task automatic req(input string tag, input logic w,
                       input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d);
        int st;
        logic [31:0] exp_d;
        logic exp_e;
        int idx;
        idx = int'(a[13:2]);
        exp_e = out_of_range(a);
        exp_d = (!w && !exp_e) ? mem_m[idx] : 32'h0;
        @(negedge clk);
        ce = 1'b1; we = w; addr = a; sel = s; wdata = d;
        #1;
        st = 0;
        while (stall === 1'b1 && st < 50) begin
            st++;
            @(negedge clk);
            #1;
        end
        check({tag, " stalls"}, 32'(st), 32'd3);
        check({tag, " data"}, rdata, exp_d);
        check({tag, " err"}, {31'b0, err}, {31'b0, exp_e});
        ce = 1'b0;
        if (w && !exp_e) mem_m[idx] = merge(mem_m[idx], d, s);
    endtask

    task automatic zreq(input string tag, input logic w,
                        input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d);
        int idx;
        logic e;
        idx = int'(a[13:2]);
        e = out_of_range(a);
        @(negedge clk);
        z_ce = 1'b1; z_we = w; z_addr = a; z_sel = s; z_wdata = d;
        #1;
        check({tag, " zstall"}, {31'b0, z_stall}, 32'd0);
        check({tag, " zdata"}, z_rdata,
              (!w && !e) ? mem_z[idx] : 32'h0);
        check({tag, " zerr"}, {31'b0, z_err}, {31'b0, e});
        if (w && !e) mem_z[idx] = merge(mem_z[idx], d, s);
    endtask

    initial begin
        logic [31:0] a;
        logic w;
        ce = 1'b1;
        z_ce = 1'b0;
        #12;
        check("rst stall", {31'b0, stall}, 32'd0);
        check("rst data", rdata, 32'h0);
        check("rst err", {31'b0, err}, 32'd0);
        ce = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 16; i++)
            req($sformatf("init%0d", i), 1'b1, 32'(i * 4), 4'hF,
                $urandom);

        req("sw", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        req("lw", 1'b0, 32'h10, 4'hF, 32'h0);
        check("lw const", rdata, 32'hDEADBEEF);
        req("sb", 1'b1, 32'h11, 4'b0100, 32'h5A5A5A5A);
        req("lw sb", 1'b0, 32'h10, 4'hF, 32'h0);
        check("sb const", rdata, 32'hDE5ABEEF);
        req("s0", 1'b1, 32'h10, 4'b0000, 32'hFFFFFFFF);
        req("sh", 1'b1, 32'h12, 4'b0011, 32'h12341234);
        req("lw sh", 1'b0, 32'h10, 4'hF, 32'h0);
        check("sh const", rdata, 32'hDE5A1234);

        req("oor lw", 1'b0, 32'h0001_0000, 4'hF, 32'h0);
        req("oor sw", 1'b1, 32'h0001_0000, 4'hF, 32'hA5A5A5A5);
        req("w0 lw", 1'b0, 32'h0, 4'hF, 32'h0);

        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h10; sel = 4'hF;
        wdata = 32'h11111111;
        @(negedge clk);
        ce = 1'b0;
        #1;
        check("abort wait stall", {31'b0, stall}, 32'd1);
        @(negedge clk);
        #1;
        check("abort idle stall", {31'b0, stall}, 32'd0);
        req("abort lw", 1'b0, 32'h10, 4'hF, 32'h0);

        @(negedge clk);
        ce = 1'b1; we = 1'b1; addr = 32'h10; sel = 4'hF;
        wdata = 32'h22222222;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstc stall", {31'b0, stall}, 32'd0);
        check("rstc data", rdata, 32'h0);
        check("rstc err", {31'b0, err}, 32'd0);
        @(negedge clk);
        ce = 1'b0;
        rst = 1'b1;
        req("rstc lw", 1'b0, 32'h10, 4'hF, 32'h0);

        for (int i = 0; i < 40; i++) begin
            a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0)
                a = a | (32'h1 << $urandom_range(14, 31));
            w = 1'($urandom_range(0, 1));
            req($sformatf("rnd%0d", i), w, a, 4'($urandom), $urandom);
        end

        for (int i = 0; i < 4; i++)
            zreq($sformatf("zinit%0d", i), 1'b1, 32'(i * 4), 4'hF,
                 $urandom);
        zreq("zsw", 1'b1, 32'h4, 4'hF, 32'hCAFEF00D);
        zreq("zlw", 1'b0, 32'h4, 4'hF, 32'h0);
        check("zlw const", z_rdata, 32'hCAFEF00D);
        zreq("zoor", 1'b0, 32'h0002_0004, 4'hF, 32'h0);
        for (int i = 0; i < 12; i++) begin
            a = 32'($urandom_range(0, 3) * 4);
            zreq($sformatf("zr%0ds", i), 1'b1, a, 4'($urandom), $urandom);
            zreq($sformatf("zr%0dl", i), 1'b0, a, 4'hF, 32'h0);
        end
        @(negedge clk);
        z_ce = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
